// File: rtl/board_uart_dump.sv
// Streams the Sudoku board to the UART byte sender as ASCII rows.
// Each row is followed by a CR/LF (or LF only), with one byte handed over per start/busy handshake.
module board_uart_dump #(
   parameter int ROWS   = 9,
   parameter int COLS   = 9,
   parameter int ADDR_W = 7,
   parameter bit CRLF   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   output logic [ADDR_W-1:0] cell_addr,
   input  logic [3:0]        cell_data,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic              busy,
   output logic              done
);

   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

   typedef enum logic [3:0] {
      IDLE, READ, FETCH, SEND, ACK, DRAIN, NEXT, EOL, FIN
   } state_t;

   state_t            state, state_d;
   logic [RW-1:0]     row, row_d;
   logic [CW-1:0]     col, col_d;
   logic [ADDR_W-1:0] addr_d;
   logic [7:0]        data_d;
   logic              eol_phase, eol_d;

   function automatic logic [7:0] to_ascii(input logic [3:0] v);
      if (v == 4'd0)
         return 8'h2E;
      else if (v <= 4'd9)
         return 8'h30 + {4'h0, v};
      else
         return 8'h3F;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         row       <= '0;
         col       <= '0;
         cell_addr <= '0;
         tx_data   <= '0;
         eol_phase <= 1'b0;
      end else begin
         state     <= state_d;
         row       <= row_d;
         col       <= col_d;
         cell_addr <= addr_d;
         tx_data   <= data_d;
         eol_phase <= eol_d;
      end
   end

   always_comb begin
      state_d  = state;
      row_d    = row;
      col_d    = col;
      addr_d   = cell_addr;
      data_d   = tx_data;
      eol_d    = eol_phase;
      tx_start = 1'b0;
      done     = 1'b0;
      busy     = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (go && !tx_busy) begin
               row_d   = '0;
               col_d   = '0;
               addr_d  = '0;
               eol_d   = 1'b0;
               state_d = READ;
            end
         end
         READ:  state_d = FETCH;
         FETCH: begin
            data_d  = to_ascii(cell_data);
            state_d = SEND;
         end
         SEND: begin
            tx_start = 1'b1;
            state_d  = ACK;
         end
         ACK:   if (tx_busy)  state_d = DRAIN;
         DRAIN: if (!tx_busy) state_d = NEXT;
         NEXT: begin
            // eol_phase tells whether the byte that just drained was a cell or a terminator
            if (!eol_phase) begin
               if (col != COL_LAST) begin
                  col_d   = col + CW'(1);
                  addr_d  = cell_addr + ADDR_W'(1);
                  state_d = READ;
               end else begin
                  col_d   = '0;
                  state_d = EOL;
               end
            end else if (CRLF && tx_data == 8'h0D) begin
               data_d  = 8'h0A;
               state_d = SEND;
            end else if (row != ROW_LAST) begin
               row_d   = row + RW'(1);
               addr_d  = cell_addr + ADDR_W'(1);
               eol_d   = 1'b0;
               state_d = READ;
            end else begin
               state_d = FIN;
            end
         end
         EOL: begin
            data_d  = CRLF ? 8'h0D : 8'h0A;
            eol_d   = 1'b1;
            state_d = SEND;
         end
         FIN: begin
            done    = 1'b1;
            busy    = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_board_uart_dump.sv
// Scoreboard bench for board_uart_dump: a default 9x9 CRLF instance and a 4x4 LF-only instance,
// each with a registered RAM model and a UART busy model.
module tb_board_uart_dump;

   logic       clk = 1'b0;
   logic       rst;
   logic       go_a, go_b;

   logic [6:0] cell_addr_a;
   logic [3:0] cell_data_a = '0;
   logic [7:0] tx_data_a;
   logic       tx_start_a, busy_a, done_a;
   logic       tx_busy_a = 1'b0;

   logic [3:0] cell_addr_b;
   logic [3:0] cell_data_b = '0;
   logic [7:0] tx_data_b;
   logic       tx_start_b, busy_b, done_b;
   logic       tx_busy_b = 1'b0;

   logic [3:0] mem_a [0:127];
   logic [3:0] mem_b [0:15];
   int         len_a, len_b;
   int         cnt_a = 0, cnt_b = 0;

   logic [7:0] q_a[$], q_b[$], log_a[$], log_b[$];
   int         done_cnt_a = 0, done_cnt_b = 0;
   int         checks = 0, failures = 0;

   always #5 clk = ~clk;

   board_uart_dump dut_a (
      .clk(clk), .rst(rst), .go(go_a), .cell_addr(cell_addr_a), .cell_data(cell_data_a),
      .tx_data(tx_data_a), .tx_start(tx_start_a), .tx_busy(tx_busy_a), .busy(busy_a), .done(done_a)
   );

   board_uart_dump #(.ROWS(4), .COLS(4), .ADDR_W(4), .CRLF(1'b0)) dut_b (
      .clk(clk), .rst(rst), .go(go_b), .cell_addr(cell_addr_b), .cell_data(cell_data_b),
      .tx_data(tx_data_b), .tx_start(tx_start_b), .tx_busy(tx_busy_b), .busy(busy_b), .done(done_b)
   );

   always @(posedge clk) cell_data_a <= mem_a[cell_addr_a];
   always @(posedge clk) cell_data_b <= mem_b[cell_addr_b];

   always @(posedge clk) begin
      if (cnt_a != 0) begin
         if (cnt_a == 1) tx_busy_a <= 1'b0;
         cnt_a <= cnt_a - 1;
      end else if (tx_start_a) begin
         tx_busy_a <= 1'b1;
         cnt_a     <= len_a;
      end
   end

   always @(posedge clk) begin
      if (cnt_b != 0) begin
         if (cnt_b == 1) tx_busy_b <= 1'b0;
         cnt_b <= cnt_b - 1;
      end else if (tx_start_b) begin
         tx_busy_b <= 1'b1;
         cnt_b     <= len_b;
      end
   end

   function automatic logic [7:0] exp_ascii(input logic [3:0] v);
      if (v == 4'd0) return 8'h2E;
      if (v < 4'd10) return 8'h30 + {4'h0, v};
      return 8'h3F;
   endfunction

   task automatic monitor_a();
      logic [7:0] cap, exp;
      bit prev, stab;
      prev = 0; stab = 0; cap = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev = 0; stab = 0;
         end else begin
            if (tx_start_a) begin
               checks++;
               if (tx_busy_a !== 1'b0 || prev) begin
                  failures++;
                  $display("FAIL start_legal_a: tx_busy=%b prev_start=%b required 0,0", tx_busy_a, prev);
               end
               checks++;
               if (q_a.size() == 0) begin
                  failures++;
                  $display("FAIL byte_a: got %h with empty scoreboard", tx_data_a);
               end else begin
                  exp = q_a.pop_front();
                  if (tx_data_a !== exp) begin
                     failures++;
                     $display("FAIL byte_a[%0d]: got %h expected %h", log_a.size(), tx_data_a, exp);
                  end
               end
               log_a.push_back(tx_data_a);
               cap  = tx_data_a;
               stab = 1;
            end else if (stab && tx_busy_a && busy_a) begin
               checks++;
               if (tx_data_a !== cap) begin
                  failures++;
                  $display("FAIL stable_a: tx_data %h changed from %h during busy", tx_data_a, cap);
               end
            end
            if (done_a) begin
               done_cnt_a++;
               checks++;
               if (busy_a !== 1'b0 || q_a.size() != 0 || tx_busy_a !== 1'b0) begin
                  failures++;
                  $display("FAIL done_a: busy=%b pending=%0d tx_busy=%b required 0,0,0",
                           busy_a, q_a.size(), tx_busy_a);
               end
            end
            prev = tx_start_a;
         end
      end
   endtask

   task automatic monitor_b();
      logic [7:0] exp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (tx_start_b) begin
               checks++;
               if (q_b.size() == 0) begin
                  failures++;
                  $display("FAIL byte_b: got %h with empty scoreboard", tx_data_b);
               end else begin
                  exp = q_b.pop_front();
                  if (tx_data_b !== exp) begin
                     failures++;
                     $display("FAIL byte_b[%0d]: got %h expected %h", log_b.size(), tx_data_b, exp);
                  end
               end
               log_b.push_back(tx_data_b);
            end
            if (done_b) begin
               done_cnt_b++;
               checks++;
               if (busy_b !== 1'b0 || q_b.size() != 0) begin
                  failures++;
                  $display("FAIL done_b: busy=%b pending=%0d required 0,0", busy_b, q_b.size());
               end
            end
         end
      end
   endtask

   task automatic push_expected_a();
      for (int r = 0; r < 9; r++) begin
         for (int c = 0; c < 9; c++) q_a.push_back(exp_ascii(mem_a[r*9+c]));
         q_a.push_back(8'h0D);
         q_a.push_back(8'h0A);
      end
   endtask

   task automatic pulse_go_a();
      @(negedge clk); go_a = 1'b1;
      @(negedge clk); go_a = 1'b0;
   endtask

   task automatic wait_done_a(input int budget, output bit ok);
      int base;
      base = done_cnt_a;
      ok = 0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk); #1;
         if (done_cnt_a != base) ok = 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy_a !== 1'b0 || tx_start_a !== 1'b0 || done_a !== 1'b0 || cell_addr_a !== 7'd0 || tx_data_a !== 8'h00) begin
         failures++;
         $display("FAIL reset_a: busy=%b start=%b done=%b addr=%0d data=%h required all zero",
                  busy_a, tx_start_a, done_a, cell_addr_a, tx_data_a);
      end
      checks++;
      if (busy_b !== 1'b0 || tx_start_b !== 1'b0 || done_b !== 1'b0 || cell_addr_b !== 4'd0) begin
         failures++;
         $display("FAIL reset_b: busy=%b start=%b done=%b addr=%0d required all zero",
                  busy_b, tx_start_b, done_b, cell_addr_b);
      end
      rst = 1'b0;
   endtask

   task automatic test_dump_default();
      bit ok;
      int d0;
      log_a.delete();
      push_expected_a();
      d0 = done_cnt_a;
      pulse_go_a();
      checks++;
      if (busy_a !== 1'b1) begin
         failures++;
         $display("FAIL busy_rise: busy=%b required 1", busy_a);
      end
      wait_done_a(5000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL done_timeout_default: no done within budget"); end
      repeat (20) @(negedge clk);
      checks++;
      if (log_a.size() != 99) begin failures++; $display("FAIL byte_count_default: got %0d expected 99", log_a.size()); end
      checks++;
      if (done_cnt_a - d0 != 1) begin failures++; $display("FAIL done_count_default: got %0d expected 1", done_cnt_a - d0); end
      checks++;
      if (log_a[0] !== 8'h2E || log_a[8] !== 8'h38 || log_a[9] !== 8'h0D || log_a[10] !== 8'h0A) begin
         failures++;
         $display("FAIL row0_bytes: got %h %h %h %h expected 2e 38 0d 0a", log_a[0], log_a[8], log_a[9], log_a[10]);
      end
      checks++;
      if (log_a[11] !== 8'h39 || log_a[12] !== 8'h2E) begin
         failures++;
         $display("FAIL row1_start: got %h %h expected 39 2e", log_a[11], log_a[12]);
      end
   endtask

   task automatic test_slow_uart();
      bit ok;
      int d0;
      len_a = 50;
      log_a.delete();
      push_expected_a();
      d0 = done_cnt_a;
      pulse_go_a();
      wait_done_a(20000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL done_timeout_slow: no done within budget"); end
      repeat (5) @(negedge clk);
      checks++;
      if (log_a.size() != 99 || done_cnt_a - d0 != 1) begin
         failures++;
         $display("FAIL slow_counts: bytes=%0d dones=%0d expected 99,1", log_a.size(), done_cnt_a - d0);
      end
      len_a = 3;
   endtask

   task automatic test_bad_cell();
      bit ok;
      mem_a[40] = 4'd12;
      log_a.delete();
      push_expected_a();
      pulse_go_a();
      wait_done_a(5000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL done_timeout_badcell: no done within budget"); end
      checks++;
      if (log_a[4*11+4] !== 8'h3F) begin
         failures++;
         $display("FAIL bad_cell: got %h expected 3f", log_a[4*11+4]);
      end
      mem_a[40] = 4'd0;
   endtask

   task automatic test_go_mid_dump();
      bit ok;
      int d0;
      log_a.delete();
      push_expected_a();
      d0 = done_cnt_a;
      pulse_go_a();
      for (int i = 0; i < 5; i++) begin
         repeat (37) @(negedge clk);
         pulse_go_a();
      end
      ok = 0;
      for (int i = 0; i < 5000 && !ok; i++) begin
         @(negedge clk); #1;
         if (done_cnt_a != d0) ok = 1;
      end
      repeat (30) @(negedge clk);
      checks++;
      if (!ok || log_a.size() != 99 || done_cnt_a - d0 != 1) begin
         failures++;
         $display("FAIL go_mid_dump: finished=%b bytes=%0d dones=%0d expected 1,99,1", ok, log_a.size(), done_cnt_a - d0);
      end
   endtask

   task automatic test_small_lf();
      bit ok;
      int d0, cr, lf_ok, lf_all;
      log_b.delete();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) q_b.push_back(exp_ascii(mem_b[r*4+c]));
         q_b.push_back(8'h0A);
      end
      d0 = done_cnt_b;
      @(negedge clk); go_b = 1'b1;
      @(negedge clk); go_b = 1'b0;
      ok = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk); #1;
         if (done_cnt_b != d0) ok = 1;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL done_timeout_small: no done within budget"); end
      cr = 0; lf_ok = 0; lf_all = 0;
      for (int i = 0; i < log_b.size(); i++) begin
         if (log_b[i] == 8'h0D) cr++;
         if (log_b[i] == 8'h0A) begin
            lf_all++;
            if (i % 5 == 4) lf_ok++;
         end
      end
      checks++;
      if (log_b.size() != 20) begin failures++; $display("FAIL small_count: got %0d expected 20", log_b.size()); end
      checks++;
      if (cr != 0 || lf_ok != 4 || lf_all != 4) begin
         failures++;
         $display("FAIL small_terminators: cr=%0d lf_at_5th=%0d lf_total=%0d expected 0,4,4", cr, lf_ok, lf_all);
      end
   endtask

   task automatic test_reset_mid_dump();
      bit ok;
      int d0;
      log_a.delete();
      push_expected_a();
      pulse_go_a();
      ok = 0;
      for (int i = 0; i < 5000 && !ok; i++) begin
         @(negedge clk); #1;
         if (log_a.size() >= 30) ok = 1;
      end
      checks++;
      if (!ok) begin failures++; $display("FAIL reach_byte30: only %0d bytes", log_a.size()); end
      d0 = done_cnt_a;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (busy_a !== 1'b0 || tx_start_a !== 1'b0 || cell_addr_a !== 7'd0 || done_a !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: busy=%b start=%b addr=%0d done=%b required 0,0,0,0",
                  busy_a, tx_start_a, cell_addr_a, done_a);
      end
      @(negedge clk); rst = 1'b0;
      q_a.delete();
      repeat (20) @(negedge clk);
      checks++;
      if (done_cnt_a != d0) begin failures++; $display("FAIL reset_no_done: got %0d dones expected 0", done_cnt_a - d0); end
      for (int i = 0; i < 200 && tx_busy_a; i++) @(negedge clk);
      log_a.delete();
      push_expected_a();
      pulse_go_a();
      wait_done_a(5000, ok);
      checks++;
      if (!ok || log_a.size() != 99 || log_a[0] !== 8'h2E) begin
         failures++;
         $display("FAIL restart: finished=%b bytes=%0d first=%h expected 1,99,2e", ok, log_a.size(), log_a[0]);
      end
   endtask

   initial begin
      rst  = 1'b1;
      go_a = 1'b0;
      go_b = 1'b0;
      len_a = 3;
      len_b = 2;
      for (int k = 0; k < 128; k++) mem_a[k] = 4'(k % 10);
      for (int k = 0; k < 16; k++)  mem_b[k] = 4'(k % 10);
      fork
         monitor_a();
         monitor_b();
      join_none
      test_reset();
      test_dump_default();
      test_slow_uart();
      test_bad_cell();
      test_go_mid_dump();
      test_small_lf();
      test_reset_mid_dump();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/board_uart_dump.md
Name: board_uart_dump

Overview:
- Sequencer that serialises the full Sudoku board to the host over the existing 8-bit UART byte transmitter.
- Reads cells from the board RAM row-major and converts each one to ASCII.
- Inserts a line terminator after every row and drives the transmitter's data/start/busy handshake one byte at a time.
- Sits between the game core (issues `go`, sees `done`) and the UART byte sender.

Parameters:
- ROWS, 9, number of board rows.
- COLS, 9, number of cells per row.
- ADDR_W, 7, cell address width; must satisfy 2^ADDR_W >= ROWS*COLS.
- CRLF, 1, 1 = terminate rows with 0x0D 0x0A; 0 = 0x0A only.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- go  in  1  one-cycle request to dump the board; ignored while busy=1.
- cell_addr  out  ADDR_W  board RAM read address = row*COLS+col.
- cell_data  in  4  RAM read data; valid exactly 1 cycle after cell_addr is presented.
- tx_data  out  8  byte to UART sender; held stable from the start pulse until the byte completes.
- tx_start  out  1  one-cycle start pulse to UART sender.
- tx_busy  in  1  UART sender busy; rises the cycle after tx_start is sampled and falls when the byte is done.
- busy  out  1  dump in progress.
- done  out  1  one-cycle pulse after the last byte has completed.

Behaviour:
- Reset: cell_addr=0, tx_data=0, tx_start=0, busy=0, done=0, row=0, col=0, state=IDLE.
- Reset mid-dump aborts immediately; no done pulse is produced.
- ASCII map, registered in FETCH:
  - 0 -> 0x2E '.'
  - 1..9 -> 0x30+v
  - 10..15 -> 0x3F '?'
- States:
  - IDLE: busy=0. On go=1 (with tx_busy=0): row=col=0, cell_addr=0, busy=1, -> READ.
  - READ: one wait cycle for RAM latency -> FETCH.
  - FETCH: latch the ASCII of cell_data into tx_data -> SEND.
  - SEND: tx_start=1 for exactly this cycle -> ACK.
  - ACK: hold until tx_busy=1 -> DRAIN. Never re-pulse start here.
  - DRAIN: hold until tx_busy=0, then -> NEXT.
  - NEXT (cell byte just finished):
    - col<COLS-1: col++, cell_addr++, -> READ.
    - Otherwise: col=0, -> EOL.
  - EOL: tx_data = 0x0D if CRLF=1, else 0x0A; -> SEND with eol_phase marked. After that byte drains:
    - if CRLF and the byte was CR: send 0x0A next.
    - else if row<ROWS-1: row++, cell_addr++, -> READ.
    - else -> FIN.
  - FIN: done=1 for 1 cycle, busy=0 -> IDLE.
- Byte count per dump = ROWS*COLS + ROWS*(1+CRLF); defaults give 99 bytes.
- busy rises the cycle after go and falls in the same cycle done pulses.
- tx_start is never asserted while tx_busy=1 or in two consecutive cycles.
- go arriving in the same cycle as done/FIN is ignored. A new dump needs a go while in IDLE.
- cell_addr changes only on entry to READ.
- cell_addr never exceeds ROWS*COLS-1; no wrap within a dump.

Test Plan:
- Board with cell k = (k mod 10), default params, go pulse:
  - 99 tx_start pulses.
  - First bytes 0x2E,0x31,...,0x38 then 0x0D,0x0A.
  - Row 2 starts 0x39,0x2E.
  - done pulses once after the 99th byte completes; busy low the same cycle.
- UART model holding tx_busy for 50 cycles per byte:
  - exactly one tx_start per byte.
  - tx_data stable across the whole busy window.
  - no start pulse while tx_busy=1.
- cell_data=12 at address 40 -> byte 0x3F sent as the 5th byte of row 5.
- CRLF=0, ROWS=COLS=4 -> 20 bytes total, every 5th byte is 0x0A, no 0x0D emitted.
- go re-pulsed mid-dump -> ignored, byte sequence unchanged, a single done.
- rst asserted after byte 30 -> next cycle busy=0, tx_start=0, cell_addr=0, no done. A following go restarts from address 0 with byte 0x2E.
